// File: rtl/usb_token_decoder.sv
// Receive-side USB token decoder: deserializes PID/ADDR/ENDP from the de-stuffed
// LSB-first bit stream, validates PID and CRC5, and strobes the result.
module usb_token_decoder #(
  parameter logic [4:0] CRC5_RESIDUAL = 5'b01100,
  parameter int         FIELD_BITS    = 16
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       bIn,
  input  logic       bInValid,
  input  logic       pktStart,
  input  logic       pktEnd,
  output logic [3:0] pid,
  output logic [6:0] addr,
  output logic [3:0] endp,
  output logic       pktValid,
  output logic       crcErr,
  output logic       pidErr,
  output logic       lenErr,
  output logic       busy
);

  // state      | meaning
  // S_IDLE     | waiting for a bit qualified by pktStart
  // S_PID      | shifting in the 8 PID bits
  // S_FIELD    | shifting ADDR/ENDP/CRC5 into the field register and CRC
  // S_WAIT_EOP | all field bits received, expecting pktEnd
  // S_DISCARD  | bad packet, swallow bits until pktEnd
  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_FIELD,
    S_WAIT_EOP,
    S_DISCARD
  } state_t;

  localparam logic [4:0] LAST_PID_CNT   = 5'd7;
  localparam logic [4:0] LAST_FIELD_CNT = 5'(FIELD_BITS - 1);

  state_t                  state_q;
  logic [4:0]              cnt_q;
  logic [7:0]              pid_sr_q;
  logic [FIELD_BITS-1:0]   field_q;
  logic [4:0]              crc_q;
  logic [3:0]              pid_q;
  logic [6:0]              addr_q;
  logic [3:0]              endp_q;
  logic                    pkt_valid_q;
  logic                    crc_err_q;
  logic                    pid_err_q;
  logic                    len_err_q;

  logic [7:0]              pid_sr_d;
  logic [FIELD_BITS-1:0]   field_d;
  logic [4:0]              crc_d;
  logic                    pid_ok;
  logic                    restart;

  assign pid_sr_d = {bIn, pid_sr_q[7:1]};
  assign field_d  = {bIn, field_q[FIELD_BITS-1:1]};
  assign crc_d    = {crc_q[3:0], 1'b0} ^ ((bIn ^ crc_q[4]) ? 5'b00101 : 5'b00000);
  // The four token PIDs (0001, 1001, 0101, 1101) are exactly those with low bits 01.
  assign pid_ok   = (pid_sr_d[7:4] == ~pid_sr_d[3:0]) && (pid_sr_d[1:0] == 2'b01);
  assign restart  = bInValid && pktStart && (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pid_sr_q    <= '0;
      field_q     <= '0;
      crc_q       <= 5'b11111;
      pid_q       <= '0;
      addr_q      <= '0;
      endp_q      <= '0;
      pkt_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      pid_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      pkt_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      pid_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      if (restart) begin
        // A new packet start aborts whatever was in flight; its bit is PID[0].
        len_err_q <= 1'b1;
        pid_sr_q  <= pid_sr_d;
        cnt_q     <= 5'd1;
        state_q   <= S_PID;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bInValid && pktStart) begin
              pid_sr_q <= pid_sr_d;
              cnt_q    <= 5'd1;
              state_q  <= S_PID;
            end
          end
          S_PID: begin
            if (pktEnd) begin
              len_err_q <= 1'b1;
              state_q   <= S_IDLE;
            end else if (bInValid) begin
              pid_sr_q <= pid_sr_d;
              if (cnt_q == LAST_PID_CNT) begin
                if (pid_ok) begin
                  cnt_q   <= '0;
                  crc_q   <= 5'b11111;
                  state_q <= S_FIELD;
                end else begin
                  pid_err_q <= 1'b1;
                  state_q   <= S_DISCARD;
                end
              end else begin
                cnt_q <= cnt_q + 5'd1;
              end
            end
          end
          S_FIELD: begin
            if (pktEnd) begin
              len_err_q <= 1'b1;
              state_q   <= S_IDLE;
            end else if (bInValid) begin
              field_q <= field_d;
              crc_q   <= crc_d;
              cnt_q   <= cnt_q + 5'd1;
              if (cnt_q == LAST_FIELD_CNT) begin
                state_q <= S_WAIT_EOP;
              end
            end
          end
          S_WAIT_EOP: begin
            if (pktEnd) begin
              if (crc_q == CRC5_RESIDUAL) begin
                pkt_valid_q <= 1'b1;
                pid_q       <= pid_sr_q[3:0];
                addr_q      <= field_q[6:0];
                endp_q      <= field_q[10:7];
              end else begin
                crc_err_q <= 1'b1;
              end
              state_q <= S_IDLE;
            end else if (bInValid) begin
              len_err_q <= 1'b1;
              state_q   <= S_DISCARD;
            end
          end
          S_DISCARD: begin
            if (pktEnd) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign pid      = pid_q;
  assign addr     = addr_q;
  assign endp     = endp_q;
  assign pktValid = pkt_valid_q;
  assign crcErr   = crc_err_q;
  assign pidErr   = pid_err_q;
  assign lenErr   = len_err_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_token_decoder.sv
// Self-checking bench for usb_token_decoder: directed protocol scenarios plus
// randomized tokens with gaps, checked against a USB CRC5 reference model.
module tb_usb_token_decoder;

  logic       clk;
  logic       rst_b;
  logic       bIn;
  logic       bInValid;
  logic       pktStart;
  logic       pktEnd;
  logic [3:0] pid;
  logic [6:0] addr;
  logic [3:0] endp;
  logic       pktValid;
  logic       crcErr;
  logic       pidErr;
  logic       lenErr;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int n_valid = 0, n_crc = 0, n_pid = 0, n_len = 0;

  logic [3:0] exp_pid;
  logic [6:0] exp_addr;
  logic [3:0] exp_endp;

  usb_token_decoder dut (
    .clk(clk), .rst_b(rst_b), .bIn(bIn), .bInValid(bInValid),
    .pktStart(pktStart), .pktEnd(pktEnd), .pid(pid), .addr(addr),
    .endp(endp), .pktValid(pktValid), .crcErr(crcErr), .pidErr(pidErr),
    .lenErr(lenErr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tally, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (rst_b) begin
      n_valid += int'(pktValid);
      n_crc   += int'(crcErr);
      n_pid   += int'(pidErr);
      n_len   += int'(lenErr);
      total++;
      if ($countones({pktValid, crcErr, pidErr, lenErr}) > 1) begin
        bad++;
        $display("FAIL one_pulse: got v/c/p/l=%b, required at most one set",
                 {pktValid, crcErr, pidErr, lenErr});
      end
    end
  end

  // Textbook USB CRC5 over the 11 ADDR/ENDP bits, LSB first.
  function automatic logic [4:0] usb_crc5(input logic [10:0] d);
    logic [4:0] c;
    c = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      if (d[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'b00101;
      else             c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  task automatic clear_counts();
    n_valid = 0; n_crc = 0; n_pid = 0; n_len = 0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bInValid = 1'b0; bIn = 1'b0; pktStart = 1'b0; pktEnd = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic s);
    @(negedge clk);
    bInValid = 1'b1; bIn = b; pktStart = s; pktEnd = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic s);
    for (int i = 0; i < 8; i++) send_bit(v[i], (i == 0) ? s : 1'b0);
  endtask

  // Whole token (PID + ADDR + ENDP + inverted CRC5 MSB first), optional flipped field bit.
  task automatic send_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                            input int flip, input bit gaps);
    logic q[$];
    logic [7:0]  pb;
    logic [10:0] d;
    logic [4:0]  c;
    pb = {~p, p};
    d  = {e, a};
    c  = usb_crc5(d);
    for (int i = 0; i < 8; i++)  q.push_back(pb[i]);
    for (int i = 0; i < 11; i++) q.push_back(d[i]);
    for (int i = 4; i >= 0; i--) q.push_back(~c[i]);
    if (flip >= 0) q[8 + flip] = ~q[8 + flip];
    foreach (q[i]) begin
      if (gaps && i != 0 && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 2)) idle_cycle();
      end
      send_bit(q[i], (i == 0));
    end
  endtask

  // Drive pktEnd for one cycle; return the strobes seen one cycle later.
  task automatic eop_sample(output logic [3:0] vcpl);
    @(negedge clk);
    bInValid = 1'b0; bIn = 1'b0; pktStart = 1'b0; pktEnd = 1'b1;
    @(negedge clk);
    pktEnd = 1'b0;
    vcpl = {pktValid, crcErr, pidErr, lenErr};
  endtask

  task automatic test_reset();
    rst_b = 1'b0; bIn = 0; bInValid = 0; pktStart = 0; pktEnd = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({pid, addr, endp, pktValid, crcErr, pidErr, lenErr, busy} !== 19'd0) begin
      bad++;
      $display("FAIL reset_state: got pid=%h addr=%h endp=%h strobes=%b busy=%b, required all 0",
               pid, addr, endp, {pktValid, crcErr, pidErr, lenErr}, busy);
    end
    rst_b = 1'b1;
    exp_pid = 0; exp_addr = 0; exp_endp = 0;
    idle_cycle();
  endtask

  task automatic test_setup_good();
    logic [3:0] r;
    send_byte(8'h2D, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    eop_sample(r);
    total++;
    if (r !== 4'b1000 || pid !== 4'b1101 || addr !== 7'd0 || endp !== 4'd0) begin
      bad++;
      $display("FAIL setup_good: got vcpl=%b pid=%b addr=%h endp=%h, required 1000 1101 0 0",
               r, pid, addr, endp);
    end
    exp_pid = 4'b1101; exp_addr = 0; exp_endp = 0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL setup_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_crc_err();
    logic [3:0] r;
    send_token(4'b0001, 7'h55, 4'hA, -1, 1'b0);
    eop_sample(r);
    total++;
    if (r !== 4'b1000 || pid !== 4'b0001 || addr !== 7'h55 || endp !== 4'hA) begin
      bad++;
      $display("FAIL crc_pre_token: got vcpl=%b pid=%b addr=%h endp=%h, required 1000 0001 55 a",
               r, pid, addr, endp);
    end
    exp_pid = 4'b0001; exp_addr = 7'h55; exp_endp = 4'hA;
    send_byte(8'h2D, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    eop_sample(r);
    total++;
    if (r !== 4'b0100 || pid !== exp_pid || addr !== exp_addr || endp !== exp_endp) begin
      bad++;
      $display("FAIL crc_err: got vcpl=%b pid=%b addr=%h endp=%h, required 0100 %b %h %h",
               r, pid, addr, endp, exp_pid, exp_addr, exp_endp);
    end
  endtask

  task automatic test_pid_err();
    logic [3:0] r;
    clear_counts();
    send_byte(8'h2C, 1'b1);
    idle_cycle();
    total++;
    if (pidErr !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pid_err_pulse: got pidErr=%b busy=%b, required 1 1", pidErr, busy);
    end
    for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    eop_sample(r);
    total++;
    if (r !== 4'b0000 || busy !== 1'b0 || n_pid !== 1 || n_crc !== 0) begin
      bad++;
      $display("FAIL pid_err_tail: got vcpl=%b busy=%b n_pid=%0d n_crc=%0d, required 0000 0 1 0",
               r, busy, n_pid, n_crc);
    end
  endtask

  task automatic test_length();
    logic [3:0] r;
    send_byte(8'h69, 1'b1);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    eop_sample(r);
    total++;
    if (r !== 4'b0001 || busy !== 1'b0) begin
      bad++;
      $display("FAIL len_short: got vcpl=%b busy=%b, required 0001 0", r, busy);
    end
    clear_counts();
    send_token(4'b1001, 7'h12, 4'h3, -1, 1'b0);
    send_bit(1'b1, 1'b0);
    idle_cycle();
    total++;
    if (lenErr !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL len_long_pulse: got lenErr=%b busy=%b, required 1 1", lenErr, busy);
    end
    eop_sample(r);
    total++;
    if (r !== 4'b0000 || busy !== 1'b0 || n_len !== 1 || n_valid !== 0 ||
        pid !== exp_pid || addr !== exp_addr) begin
      bad++;
      $display("FAIL len_long_tail: got vcpl=%b busy=%b n_len=%0d n_valid=%0d pid=%b addr=%h",
               r, busy, n_len, n_valid, pid, addr);
    end
  endtask

  task automatic test_restart();
    logic [3:0] r;
    clear_counts();
    send_byte(8'h2D, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    send_byte(8'hE1, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    eop_sample(r);
    total++;
    if (r !== 4'b1000 || pid !== 4'b0001 || addr !== 7'd0 || endp !== 4'd0 || n_len !== 1) begin
      bad++;
      $display("FAIL restart: got vcpl=%b pid=%b addr=%h endp=%h n_len=%0d, required 1000 0001 0 0 1",
               r, pid, addr, endp, n_len);
    end
    exp_pid = 4'b0001; exp_addr = 0; exp_endp = 0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] r;
    send_token(4'b1001, 7'h3C, 4'h6, -1, 1'b0);
    eop_sample(r);
    total++;
    if (r !== 4'b1000 || addr !== 7'h3C || endp !== 4'h6) begin
      bad++;
      $display("FAIL rstmid_pre: got vcpl=%b addr=%h endp=%h, required 1000 3c 6", r, addr, endp);
    end
    send_byte(8'h2D, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    bInValid = 1'b0;
    rst_b = 1'b0;
    #1;
    total++;
    if ({pid, addr, endp, busy} !== 16'd0) begin
      bad++;
      $display("FAIL rstmid_clear: got pid=%b addr=%h endp=%h busy=%b, required all 0",
               pid, addr, endp, busy);
    end
    @(negedge clk);
    rst_b = 1'b1;
    idle_cycle();
    send_token(4'b0101, 7'h7F, 4'h9, -1, 1'b1);
    eop_sample(r);
    total++;
    if (r !== 4'b1000 || pid !== 4'b0101 || addr !== 7'h7F || endp !== 4'h9) begin
      bad++;
      $display("FAIL rstmid_sof: got vcpl=%b pid=%b addr=%h endp=%h, required 1000 0101 7f 9",
               r, pid, addr, endp);
    end
    exp_pid = 4'b0101; exp_addr = 7'h7F; exp_endp = 4'h9;
  endtask

  task automatic test_random();
    logic [3:0] toks [4];
    logic [3:0] r, p, e;
    logic [6:0] a;
    int flip;
    toks[0] = 4'b0001; toks[1] = 4'b1001; toks[2] = 4'b0101; toks[3] = 4'b1101;
    for (int n = 0; n < 40; n++) begin
      p = toks[$urandom_range(0, 3)];
      a = 7'($urandom);
      e = 4'($urandom);
      flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      send_token(p, a, e, flip, 1'b1);
      if ($urandom_range(0, 1) == 1) idle_cycle();
      eop_sample(r);
      if (flip < 0) begin
        exp_pid = p; exp_addr = a; exp_endp = e;
      end
      total++;
      if (r !== ((flip < 0) ? 4'b1000 : 4'b0100) ||
          pid !== exp_pid || addr !== exp_addr || endp !== exp_endp) begin
        bad++;
        $display("FAIL random_%0d: got vcpl=%b pid=%b addr=%h endp=%h, required flip=%0d pid=%b addr=%h endp=%h",
                 n, r, pid, addr, endp, flip, exp_pid, exp_addr, exp_endp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_setup_good();
    test_crc_err();
    test_pid_err();
    test_length();
    test_restart();
    test_reset_mid();
    test_random();
    repeat (3) idle_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_token_decoder.md
Name: usb_token_decoder

Overview:
- Receive-side counterpart of the token encoder/serializer.
- Accepts the de-stuffed, NRZI-decoded serial bit stream of one USB token packet (OUT/IN/SOF/SETUP), LSB first, from SYNC-stripped framing logic.
- Deserializes PID, ADDR and ENDP; checks the PID complement and the CRC5 residual.
- Presents the decoded fields with a one-cycle valid or error strobe to the protocol FSM.

Parameters:
- CRC5_RESIDUAL, 5'b01100, required CRC5 register value after all 16 post-PID bits.
- FIELD_BITS, 16, number of bits after the PID: 7 addr + 4 endp + 5 crc.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_b  input  1  asynchronous active-low reset.
- bIn  input  1  serial data bit, meaningful only when bInValid=1.
- bInValid  input  1  qualifies bIn; at most one bit per cycle.
- pktStart  input  1  asserted with bInValid on the first PID bit (PID[0]).
- pktEnd  input  1  one-cycle EOP strobe; never coincident with bInValid.
- pid  output  4  decoded PID[3:0]; held until the next accepted packet.
- addr  output  7  decoded device address; held.
- endp  output  4  decoded endpoint; held.
- pktValid  output  1  one-cycle pulse: good token received.
- crcErr  output  1  one-cycle pulse: CRC5 residual mismatch.
- pidErr  output  1  one-cycle pulse: PID check failed or PID is not a token.
- lenErr  output  1  one-cycle pulse: too few/too many bits, or packet aborted.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_b=0): state=IDLE; pid=0, addr=0, endp=0; all pulses 0; busy=0; bit counter=0; CRC register=5'b11111.
- States: IDLE, PID, FIELD, WAIT_EOP, DISCARD.
- IDLE:
  - bInValid&pktStart: shift bIn into PID shift reg, cnt=1, go PID.
  - bInValid without pktStart: ignored.
  - pktEnd: ignored.
- PID: each valid bit shifts in LSB-first. On the 8th bit:
  - Accepted when byte[7:4]==~byte[3:0] and byte[3:0] is one of OUT 0001, IN 1001, SOF 0101, SETUP 1101. Then go FIELD, cnt=0, CRC=5'b11111.
  - Otherwise pidErr pulses the next cycle and the state goes to DISCARD.
- FIELD:
  - Each valid bit is shifted into a 16-bit field register (LSB first) and into the CRC5.
  - CRC update: fb=bIn^crc[4]; crc={crc[3:0],1'b0}^(fb?5'b00101:5'b00000).
  - After the 16th bit, go WAIT_EOP.
- WAIT_EOP:
  - pktEnd with crc==CRC5_RESIDUAL: next cycle pktValid=1. pid, addr=field[6:0] and endp=field[10:7] update in that same cycle. Go IDLE.
  - pktEnd with a mismatch: crcErr pulse. Outputs are not updated. Go IDLE.
  - bInValid (extra bit): lenErr pulse, go DISCARD.
- DISCARD: ignore bits; pktEnd → IDLE, with no further pulse.
- pktEnd in PID or FIELD (short packet): lenErr pulse, go IDLE.
- pktStart&bInValid in any non-IDLE state:
  - Current packet aborted with a lenErr pulse.
  - The bit is taken as PID[0] of a new packet; state=PID, cnt=1.
  - lenErr takes priority over any other pulse in that cycle.
- Latency: pktValid/crcErr appear exactly 1 cycle after the pktEnd sample. At most one pulse is asserted per cycle.
- Gaps (bInValid=0) anywhere inside a packet are legal and only stall progress.
- Counter: 5-bit, saturating not required; it never exceeds 16 by construction.
- Field outputs change only on pktValid, so consumers may sample them whenever pktValid=1 or afterward.

Test Plan:
- SETUP to addr 0, endp 0: bytes 0x2D,0x00,0x10 LSB first, then pktEnd → pktValid 1 cycle later; pid=4'b1101, addr=0, endp=0; no error pulse.
- Same packet with the last byte 0x11 → crcErr pulse; pid/addr/endp keep prior values; pktValid stays 0.
- PID byte 0x2C (complement fails), then 16 bits and pktEnd → pidErr one cycle after the 8th bit; no crcErr; state IDLE after pktEnd.
- IN packet cut after 10 field bits by pktEnd → lenErr pulse, IDLE. Separately, 17 field bits → lenErr on the 17th bit, then IDLE after pktEnd.
- New pktStart during FIELD, followed by a full valid OUT token (0xE1,0x00,0x10) → lenErr once, then pktValid with pid=0001.
- rst_b dropped mid-FIELD → outputs cleared immediately; a following valid SOF packet decodes normally. Random tokens with random bInValid gaps are checked against a software CRC5 model.
